// File: rtl/spi_mem_loader.sv
// SPI slave (mode 0, oversampled in clk_i) that turns host write/read frames into word requests on the memory bus.
// Optional build macro SPI_AUTOINC_EN: keep writing consecutive words (address + 4) while chip select stays low.
module spi_mem_loader #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned DUMMY_CYCLES = 8,
   parameter logic [7:0]  CMD_WR       = 8'h02,
   parameter logic [7:0]  CMD_RD       = 8'h0B
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              spi_sclk,
   input  logic              spi_cs,
   input  logic              spi_sdi0,
   output logic              spi_sdo0,
   output logic [1:0]        spi_mode,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic              err_o
);

   localparam int unsigned SH_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

   typedef enum logic [3:0] {
      IDLE, CMD, ADDR, DATA, WR_REQ, RD_REQ, DUMMY, RD_OUT, IGNORE
   } state_e;

   logic sclk_s1_q, sclk_s2_q, sclk_d_q;
   logic cs_s1_q, cs_s2_q, cs_d_q;
   logic sdi_s1_q, sdi_s2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_s1_q <= 1'b0;
         sclk_s2_q <= 1'b0;
         sclk_d_q  <= 1'b0;
         cs_s1_q   <= 1'b1;
         cs_s2_q   <= 1'b1;
         cs_d_q    <= 1'b1;
         sdi_s1_q  <= 1'b0;
         sdi_s2_q  <= 1'b0;
      end else begin
         sclk_s1_q <= spi_sclk;
         sclk_s2_q <= sclk_s1_q;
         sclk_d_q  <= sclk_s2_q;
         cs_s1_q   <= spi_cs;
         cs_s2_q   <= cs_s1_q;
         cs_d_q    <= cs_s2_q;
         sdi_s1_q  <= spi_sdi0;
         sdi_s2_q  <= sdi_s1_q;
      end
   end

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   assign sclk_rise = sclk_s2_q & ~sclk_d_q;
   assign sclk_fall = ~sclk_s2_q & sclk_d_q;
   assign cs_rise   = cs_s2_q & ~cs_d_q;
   assign cs_fall   = ~cs_s2_q & cs_d_q;

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [SH_W-1:0]   sh_q, sh_d, full;
   logic              is_rd_q, is_rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, mem_wdata_q, mem_wdata_d;
   logic              issued_q, issued_d;
   logic              req_q, req_d, we_q, we_d;
   logic              rd_wait_q, rd_wait_d, rd_got_q, rd_got_d;
   logic [DATA_W-1:0] rd_sr_q, rd_sr_d;
   logic              sdo_q, sdo_d, err_q, err_d;
   logic              grant, rvalid_take;

   assign full        = {sh_q[SH_W-2:0], sdi_s2_q};
   assign grant       = req_q & mem_gnt_i;
   assign rvalid_take = rd_wait_q & mem_rvalid_i;

   // The bus request lives apart from the frame FSM so a chip-select abort never withdraws an ungranted request.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      is_rd_d     = is_rd_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      issued_d    = issued_q;
      req_d       = req_q;
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_wait_d   = rd_wait_q;
      rd_got_d    = rd_got_q;
      rd_sr_d     = rd_sr_q;
      sdo_d       = sdo_q;
      err_d       = 1'b0;

      if (grant) begin
         req_d = 1'b0;
         if (!we_q) rd_wait_d = 1'b1;
      end
      if (rvalid_take) begin
         rd_wait_d = 1'b0;
         if (state_q == DUMMY) begin
            rd_sr_d  = mem_rdata_i;
            rd_got_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = CMD;
               cnt_d   = '0;
            end
         end
         CMD: begin
            if (sclk_rise) begin
               sh_d  = full;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'd7) begin
                  cnt_d = '0;
                  if (full[7:0] == CMD_WR) begin
                     state_d = ADDR;
                     is_rd_d = 1'b0;
                  end else if (full[7:0] == CMD_RD) begin
                     state_d = ADDR;
                     is_rd_d = 1'b1;
                  end else begin
                     state_d = IGNORE;
                     err_d   = 1'b1;
                  end
               end
            end
         end
         ADDR: begin
            if (sclk_rise) begin
               sh_d  = full;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'(ADDR_W - 1)) begin
                  cnt_d    = '0;
                  addr_d   = {full[ADDR_W-1:2], 2'b00};
                  issued_d = 1'b0;
                  state_d  = is_rd_q ? RD_REQ : DATA;
               end
            end
         end
         DATA: begin
            if (sclk_rise) begin
               sh_d  = full;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'(DATA_W - 1)) begin
                  cnt_d    = '0;
                  wdata_d  = full[DATA_W-1:0];
                  state_d  = WR_REQ;
                  issued_d = 1'b0;
                  if (!req_q) begin
                     req_d       = 1'b1;
                     we_d        = 1'b1;
                     mem_addr_d  = addr_q;
                     mem_wdata_d = full[DATA_W-1:0];
                     issued_d    = 1'b1;
                  end
               end
            end
         end
         WR_REQ: begin
            if (!issued_q) begin
               if (!req_q) begin
                  req_d       = 1'b1;
                  we_d        = 1'b1;
                  mem_addr_d  = addr_q;
                  mem_wdata_d = wdata_q;
                  issued_d    = 1'b1;
               end
            end else if (grant) begin
               issued_d = 1'b0;
`ifdef SPI_AUTOINC_EN
               state_d = DATA;
               cnt_d   = '0;
               addr_d  = addr_q + ADDR_W'(4);
`else
               state_d = IGNORE;
`endif
            end
         end
         RD_REQ: begin
            if (!issued_q) begin
               if (!req_q && !rd_wait_q) begin
                  req_d      = 1'b1;
                  we_d       = 1'b0;
                  mem_addr_d = addr_q;
                  rd_got_d   = 1'b0;
                  issued_d   = 1'b1;
               end
            end else if (grant) begin
               issued_d = 1'b0;
               state_d  = DUMMY;
               cnt_d    = '0;
            end
         end
         DUMMY: begin
            if (sclk_rise) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'(DUMMY_CYCLES - 1)) begin
                  cnt_d   = '0;
                  state_d = RD_OUT;
                  if (!rd_got_q && !rvalid_take) begin
                     err_d   = 1'b1;
                     rd_sr_d = '0;
                  end
               end
            end
         end
         RD_OUT: begin
            // Stay here until the rise that samples the last bit, so the host still sees bit 0.
            if (sclk_fall && cnt_q != 8'(DATA_W)) begin
               sdo_d   = rd_sr_q[DATA_W-1];
               rd_sr_d = {rd_sr_q[DATA_W-2:0], 1'b0};
               cnt_d   = cnt_q + 8'd1;
            end else if (sclk_rise && cnt_q == 8'(DATA_W)) begin
               state_d = IGNORE;
            end
         end
         IGNORE: begin
         end
         default: state_d = IDLE;
      endcase

      if (cs_rise) begin
         state_d  = IDLE;
         cnt_d    = '0;
         issued_d = 1'b0;
         req_d    = req_q & ~mem_gnt_i;
      end
      if (state_d != RD_OUT) sdo_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         is_rd_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         issued_q    <= 1'b0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_wait_q   <= 1'b0;
         rd_got_q    <= 1'b0;
         rd_sr_q     <= '0;
         sdo_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         is_rd_q     <= is_rd_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         issued_q    <= issued_d;
         req_q       <= req_d;
         we_q        <= we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_wait_q   <= rd_wait_d;
         rd_got_q    <= rd_got_d;
         rd_sr_q     <= rd_sr_d;
         sdo_q       <= sdo_d;
         err_q       <= err_d;
      end
   end

   assign spi_sdo0    = sdo_q;
   assign spi_mode    = 2'b00;
   assign mem_req_o   = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = 4'hF;
   assign busy_o      = (state_q != IDLE) | req_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed bench for spi_mem_loader: a memory responder plus a request scoreboard built from the frame-level rules.
module tb_spi_mem_loader;

   localparam int HALF = 8;
   localparam int GAP  = 160;
`ifdef SPI_AUTOINC_EN
   localparam logic AUTO = 1'b1;
`else
   localparam logic AUTO = 1'b0;
`endif

   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        spi_sclk = 1'b0, spi_cs = 1'b1, spi_sdi0 = 1'b0;
   logic        spi_sdo0;
   logic [1:0]  spi_mode;
   logic        mem_req_o, mem_we_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
   logic [3:0]  mem_be_o;
   logic        busy_o, err_o;

   always #5 clk_i = ~clk_i;

   spi_mem_loader dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .spi_sclk(spi_sclk), .spi_cs(spi_cs),
      .spi_sdi0(spi_sdi0), .spi_sdo0(spi_sdo0), .spi_mode(spi_mode),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   req_t        exp_q[$];
   req_t        cur;
   logic [31:0] mem_model [logic [31:0]];
   int          gnt_delay = 0, rv_delay = 2, req_age = 0, last_req_len = 0, rv_timer = 0;
   int          err_seen = 0;
   logic        gnt_prev = 1'b0, err_prev = 1'b0;
   logic [31:0] rd_addr = '0;
   int          checks_total = 0, checks_passed = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Memory responder and scoreboard: every request cycle is checked against the request the frame implies.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         req_age      = 0;
         rv_timer     = 0;
         gnt_prev     = 1'b0;
         err_prev     = 1'b0;
      end else begin
         if (gnt_prev) checkOutput("req_drop", mem_req_o, 0);
         if (err_prev) checkOutput("err_width", err_o, 0);
         if (err_o) err_seen++;
         err_prev     = err_o;
         gnt_prev     = 1'b0;
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         if (rv_timer > 0) begin
            rv_timer--;
            if (rv_timer == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = mem_model.exists(rd_addr) ? mem_model[rd_addr] : 32'h0;
            end
         end
         if (mem_req_o) begin
            if (req_age == 0) begin
               checkOutput("req_expected", exp_q.size() != 0, 1);
               cur = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            end
            checkOutput("req_we", mem_we_o, cur.we);
            checkOutput("req_addr", mem_addr_o, cur.addr);
            if (cur.we) checkOutput("req_wdata", mem_wdata_o, cur.data);
            checkOutput("req_be", mem_be_o, 4'hF);
            req_age++;
            if (req_age > gnt_delay) begin
               mem_gnt_i    = 1'b1;
               gnt_prev     = 1'b1;
               last_req_len = req_age;
               req_age      = 0;
               if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
               else begin
                  rd_addr  = mem_addr_o;
                  rv_timer = rv_delay;
               end
            end
         end else begin
            req_age = 0;
         end
      end
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic spiBits(input logic [31:0] v, input int n, output logic [31:0] r);
      r = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_sdi0 = v[i];
         waitClk(HALF);
         r = {r[30:0], spi_sdo0};
         spi_sclk = 1'b1;
         waitClk(HALF);
         spi_sclk = 1'b0;
      end
   endtask

   // Frame-level model: one write per frame, or one per data word when auto-increment is built in.
   task automatic modelWrite(input logic [31:0] addr, input logic [31:0] w0, w1, w2, input int n);
      logic [31:0] w [3];
      w[0] = w0; w[1] = w1; w[2] = w2;
      for (int i = 0; i < n; i++)
         if (AUTO || i == 0) exp_q.push_back('{1'b1, (addr + 32'(4 * i)) & ~32'h3, w[i]});
   endtask

   task automatic modelRead(input logic [31:0] addr);
      exp_q.push_back('{1'b0, addr & ~32'h3, 32'h0});
   endtask

   task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr,
                                input logic [31:0] w0, w1, w2, input int nwords,
                                output logic [31:0] rd, output logic [31:0] side);
      logic [31:0] r;
      logic [31:0] w [3];
      w[0] = w0; w[1] = w1; w[2] = w2;
      rd = '0;
      spi_cs = 1'b0;
      waitClk(HALF);
      spiBits({24'h0, cmd}, 8, r);
      side = r;
      spiBits(addr, 32, r);
      side |= r;
      if (cmd == 8'h0B) begin
         spiBits(32'h0, 8, r);
         side |= r;
         spiBits(32'h0, 32, rd);
      end else begin
         for (int i = 0; i < nwords; i++) begin
            spiBits(w[i], 32, r);
            side |= r;
         end
      end
      waitClk(HALF);
      spi_cs = 1'b1;
      waitClk(GAP);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd, side, r;
      int e0;

      waitClk(5);
      checkOutput("rst_req", mem_req_o, 0);
      checkOutput("rst_we", mem_we_o, 0);
      checkOutput("rst_addr", mem_addr_o, 0);
      checkOutput("rst_wdata", mem_wdata_o, 0);
      checkOutput("rst_be", mem_be_o, 4'hF);
      checkOutput("rst_mode", spi_mode, 2'b00);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_err", err_o, 0);
      checkOutput("rst_sdo", spi_sdo0, 0);
      rst_ni = 1'b1;
      waitClk(5);
      $display("[TB] write 0x80 = 0xFFF, immediate grant");
      modelWrite(32'h80, 32'hFFF, 0, 0, 1);
      applyStimulus(8'h02, 32'h80, 32'hFFF, 0, 0, 1, rd, side);
      checkOutput("wr_all_reqs", exp_q.size(), 0);
      checkOutput("wr_req_len", last_req_len, 1);
      checkOutput("wr_mem", mem_model[32'h80], 32'hFFF);
      checkOutput("wr_sdo_quiet", side, 0);
      checkOutput("wr_busy_after", busy_o, 0);

      $display("[TB] write with 5-cycle grant delay");
      mem_model.delete(32'h80);
      gnt_delay = 5;
      modelWrite(32'h80, 32'hFFF, 0, 0, 1);
      applyStimulus(8'h02, 32'h80, 32'hFFF, 0, 0, 1, rd, side);
      checkOutput("bp_all_reqs", exp_q.size(), 0);
      checkOutput("bp_req_len", last_req_len, 6);
      checkOutput("bp_mem", mem_model[32'h80], 32'hFFF);
      gnt_delay = 0;

      $display("[TB] read 0x84");
      mem_model[32'h84] = 32'hDEADBEEF;
      e0 = err_seen;
      modelRead(32'h84);
      applyStimulus(8'h0B, 32'h84, 0, 0, 0, 0, rd, side);
      checkOutput("rd_data", rd, 32'hDEADBEEF);
      checkOutput("rd_no_err", err_seen - e0, 0);
      checkOutput("rd_sdo_quiet", side, 0);
      checkOutput("rd_all_reqs", exp_q.size(), 0);

      $display("[TB] abort after 20 address bits");
      spi_cs = 1'b0;
      waitClk(HALF);
      spiBits(32'h02, 8, r);
      spiBits(32'h0, 20, r);
      checkOutput("abort_busy_mid", busy_o, 1);
      waitClk(HALF);
      spi_cs = 1'b1;
      waitClk(GAP);
      checkOutput("abort_busy_after", busy_o, 0);
      checkOutput("abort_no_write", mem_model.exists(32'h88), 0);
      modelWrite(32'h88, 32'h12345678, 0, 0, 1);
      applyStimulus(8'h02, 32'h88, 32'h12345678, 0, 0, 1, rd, side);
      checkOutput("abort_next_mem", mem_model[32'h88], 32'h12345678);
      checkOutput("abort_all_reqs", exp_q.size(), 0);

      $display("[TB] unknown command 0x55");
      e0 = err_seen;
      applyStimulus(8'h55, 32'hFFFF_FFFF, 32'hA5A5A5A5, 0, 0, 1, rd, side);
      checkOutput("unk_err_once", err_seen - e0, 1);
      checkOutput("unk_sdo_quiet", side, 0);
      checkOutput("unk_busy_after", busy_o, 0);

      $display("[TB] read with late rvalid");
      mem_model[32'h8C] = 32'hCAFEF00D;
      rv_delay = 300;
      e0 = err_seen;
      modelRead(32'h8C);
      applyStimulus(8'h0B, 32'h8C, 0, 0, 0, 0, rd, side);
      checkOutput("late_rd_zero", rd, 0);
      checkOutput("late_rd_err", err_seen - e0, 1);
      waitClk(300);
      rv_delay = 2;

      $display("[TB] reset asserted mid-frame");
      spi_cs = 1'b0;
      waitClk(HALF);
      spiBits(32'h02, 8, r);
      spiBits(32'h0, 10, r);
      rst_ni = 1'b0;
      #1;
      checkOutput("midrst_busy", busy_o, 0);
      checkOutput("midrst_req", mem_req_o, 0);
      waitClk(4);
      spi_cs = 1'b1;
      rst_ni = 1'b1;
      waitClk(GAP);

      $display("[TB] three data words at 0x100");
      modelWrite(32'h100, 32'h1, 32'h2, 32'h3, 3);
      applyStimulus(8'h02, 32'h100, 32'h1, 32'h2, 32'h3, 3, rd, side);
      checkOutput("ai_mem_100", mem_model[32'h100], 32'h1);
      checkOutput("ai_has_104", mem_model.exists(32'h104), AUTO);
      checkOutput("ai_has_108", mem_model.exists(32'h108), AUTO);
      checkOutput("ai_all_reqs", exp_q.size(), 0);
      checkOutput("end_mode", spi_mode, 2'b00);
      checkOutput("end_busy", busy_o, 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
